// File: rtl/ttl_74194_shift_seq_pkg.sv
// Shared mode codes, FSM states and sizing helper for the 74194 shift-register sequencer.
package ttl_shift_seq_pkg;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  function automatic int cnt_width(input int pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

endpackage

// File: rtl/ttl_74194_shift_seq_if.sv
// Pixel-row word handshake between the word producer and the shift sequencer.
interface ttl_74194_shift_seq_if #(
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4*LANES-1:0]   in_data;
  logic                 in_flip;

  modport master (output in_valid, output in_data, output in_flip, input in_ready);
  modport slave  (input in_valid, input in_data, input in_flip, output in_ready);
endinterface

// File: rtl/ttl_74194_shift_seq_pend.sv
// One-entry pending word register; ready only when empty so a pop and a push never share a cycle.
module ttl_shift_seq_pend #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_flip,
  input  logic         pop,
  output logic         in_ready,
  output logic         pend_valid,
  output logic [W-1:0] pend_data,
  output logic         pend_flip
);

  logic push;

  assign in_ready = !pend_valid && !rst;
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_flip  <= 1'b0;
    end else begin
      if (push) begin
        pend_valid <= 1'b1;
        pend_data  <= in_data;
        pend_flip  <= in_flip;
      end else if (pop) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ttl_74194_shift_seq.sv
// Sequencer driving LANES 74194 shifters: one LOAD/shift/HOLD per pce, registered one clk later.
// Optional macro TTL_SHIFT_SEQ_BLANK_EN: an underrun clears the shifters instead of a HOLD pulse.
module ttl_74194_shift_seq
  import ttl_shift_seq_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int PIXELS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pce,
  ttl_74194_shift_seq_if.slave bus,
  input  logic                 underrun_clr,
  output logic                 sh_cen,
  output logic                 sh_cr_n,
  output logic [1:0]           sh_s,
  output logic [4*LANES-1:0]   sh_d,
  output logic                 sh_dsl,
  output logic                 sh_dsr,
  output logic                 busy,
  output logic                 underrun
);

  localparam int W  = 4 * LANES;
  localparam int CW = cnt_width(PIXELS);
  localparam logic [CW-1:0] CNT_INIT = CW'(PIXELS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip_q, flip_d;
  logic          cen_d, crn_d, under_d;
  logic [1:0]    s_d;
  logic [W-1:0]  d_d;
  logic          do_load;
  logic          pop;
  logic          pend_valid;
  logic [W-1:0]  pend_data;
  logic          pend_flip;

  ttl_shift_seq_pend #(.W(W)) u_pend (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (bus.in_valid),
    .in_data    (bus.in_data),
    .in_flip    (bus.in_flip),
    .pop        (pop),
    .in_ready   (bus.in_ready),
    .pend_valid (pend_valid),
    .pend_data  (pend_data),
    .pend_flip  (pend_flip)
  );

  assign sh_dsl = 1'b0;
  assign sh_dsr = 1'b0;
  assign busy   = (state_q == ST_SHIFT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip_d  = flip_q;
    cen_d   = 1'b0;
    crn_d   = 1'b1;
    s_d     = sh_s;
    d_d     = sh_d;
    under_d = underrun;
    do_load = 1'b0;
    pop     = 1'b0;

    if (underrun_clr) under_d = 1'b0;

    if (pce) begin
      case (state_q)
        ST_IDLE: begin
          if (pend_valid) do_load = 1'b1;
        end
        ST_SHIFT: begin
          if (cnt_q != '0) begin
            cen_d = 1'b1;
            s_d   = flip_q ? S_SHL : S_SHR;
            cnt_d = cnt_q - CW'(1);
          end else if (pend_valid) begin
            do_load = 1'b1;
          end else begin
            // Starved: the set must override a same-cycle underrun_clr.
            under_d = 1'b1;
            state_d = ST_IDLE;
            s_d     = S_HOLD;
`ifdef TTL_SHIFT_SEQ_BLANK_EN
            crn_d   = 1'b0;
`else
            cen_d   = 1'b1;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (do_load) begin
      cen_d   = 1'b1;
      s_d     = S_LOAD;
      d_d     = pend_data;
      flip_d  = pend_flip;
      cnt_d   = CNT_INIT;
      pop     = 1'b1;
      state_d = (PIXELS == 1) ? ST_IDLE : ST_SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      flip_q   <= 1'b0;
      sh_cen   <= 1'b0;
      sh_cr_n  <= 1'b0;
      sh_s     <= S_HOLD;
      sh_d     <= '0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flip_q   <= flip_d;
      sh_cen   <= cen_d;
      sh_cr_n  <= crn_d;
      sh_s     <= s_d;
      sh_d     <= d_d;
      underrun <= under_d;
    end
  end

endmodule

// File: tb/tb_ttl_74194_shift_seq.sv
// Directed bench for ttl_74194_shift_seq: PIXELS=4 main instance plus a PIXELS=1 instance.
module tb_ttl_74194_shift_seq;
  import ttl_shift_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pce;
  logic        pce1;
  logic        underrun_clr;

  logic        sh_cen, sh_cr_n, sh_dsl, sh_dsr, busy, underrun;
  logic [1:0]  sh_s;
  logic [15:0] sh_d;

  logic        p1_cen, p1_cr_n, p1_dsl, p1_dsr, p1_busy, p1_underrun;
  logic [1:0]  p1_s;
  logic [15:0] p1_d;

  int tests = 0;
  int fails = 0;

  ttl_74194_shift_seq_if #(.LANES(4)) bus ();
  ttl_74194_shift_seq_if #(.LANES(4)) bus1 ();

  ttl_74194_shift_seq #(.LANES(4), .PIXELS(4)) dut (
    .clk(clk), .rst(rst), .pce(pce), .bus(bus), .underrun_clr(underrun_clr),
    .sh_cen(sh_cen), .sh_cr_n(sh_cr_n), .sh_s(sh_s), .sh_d(sh_d),
    .sh_dsl(sh_dsl), .sh_dsr(sh_dsr), .busy(busy), .underrun(underrun)
  );

  ttl_74194_shift_seq #(.LANES(4), .PIXELS(1)) dut1 (
    .clk(clk), .rst(rst), .pce(pce1), .bus(bus1), .underrun_clr(1'b0),
    .sh_cen(p1_cen), .sh_cr_n(p1_cr_n), .sh_s(p1_s), .sh_d(p1_d),
    .sh_dsl(p1_dsl), .sh_dsr(p1_dsr), .busy(p1_busy), .underrun(p1_underrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clk of stimulus on the main instance; pce and in_valid are single-cycle pulses.
  task automatic applyStimulus(input logic p, input logic v, input logic [15:0] data, input logic flip);
    pce          = p;
    bus.in_valid = v;
    bus.in_data  = data;
    bus.in_flip  = flip;
    tick();
    pce          = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic pceSlot(input string tag, input logic [1:0] exp_s, input logic [15:0] exp_d);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput({tag, "_cen"}, 16'(sh_cen), 16'h1);
    checkOutput({tag, "_s"}, 16'(sh_s), 16'(exp_s));
    checkOutput({tag, "_d"}, sh_d, exp_d);
    tick();
    checkOutput({tag, "_cen_low"}, 16'(sh_cen), 16'h0);
    checkOutput({tag, "_s_held"}, 16'(sh_s), 16'(exp_s));
    tick();
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    pce           = 1'b0;
    pce1          = 1'b0;
    underrun_clr  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_flip   = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    bus1.in_flip  = 1'b0;

    tick();
    tick();
    checkOutput("rst_cen", 16'(sh_cen), 16'h0);
    checkOutput("rst_cr_n", 16'(sh_cr_n), 16'h0);
    checkOutput("rst_s", 16'(sh_s), 16'h0);
    checkOutput("rst_d", sh_d, 16'h0);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_underrun", 16'(underrun), 16'h0);
    checkOutput("rst_in_ready", 16'(bus.in_ready), 16'h0);
    checkOutput("rst_dsl_dsr", 16'({sh_dsl, sh_dsr}), 16'h0);
    rst = 1'b0;
    tick();
    checkOutput("rel_cr_n", 16'(sh_cr_n), 16'h1);
    checkOutput("rel_in_ready", 16'(bus.in_ready), 16'h1);

    // Single word, flip=0: LOAD then three right shifts.
    applyStimulus(1'b0, 1'b1, 16'hA5F0, 1'b0);
    checkOutput("w0_in_ready", 16'(bus.in_ready), 16'h0);
    checkOutput("w0_busy_idle", 16'(busy), 16'h0);
    pceSlot("w0_load", S_LOAD, 16'hA5F0);
    checkOutput("w0_busy", 16'(busy), 16'h1);
    checkOutput("w0_ready_after_load", 16'(bus.in_ready), 16'h1);
    for (int i = 0; i < 3; i++) pceSlot("w0_shr", S_SHR, 16'hA5F0);

    // Fifth pce with nothing pending: underrun.
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
`ifdef TTL_SHIFT_SEQ_BLANK_EN
    checkOutput("ur_cen", 16'(sh_cen), 16'h0);
    checkOutput("ur_cr_n", 16'(sh_cr_n), 16'h0);
`else
    checkOutput("ur_cen", 16'(sh_cen), 16'h1);
    checkOutput("ur_cr_n", 16'(sh_cr_n), 16'h1);
`endif
    checkOutput("ur_s", 16'(sh_s), 16'(S_HOLD));
    checkOutput("ur_flag", 16'(underrun), 16'h1);
    checkOutput("ur_busy", 16'(busy), 16'h0);
    tick();
    checkOutput("ur_cen_after", 16'(sh_cen), 16'h0);
    checkOutput("ur_cr_n_after", 16'(sh_cr_n), 16'h1);
    checkOutput("ur_sticky", 16'(underrun), 16'h1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    checkOutput("ur_cleared", 16'(underrun), 16'h0);

    // Back-to-back words: flip=0 then flip=1, no gap between them.
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
    pceSlot("bb_load0", S_LOAD, 16'h1234);
    applyStimulus(1'b0, 1'b1, 16'h8C3E, 1'b1);
    checkOutput("bb_pend_full", 16'(bus.in_ready), 16'h0);
    for (int i = 0; i < 3; i++) pceSlot("bb_shr", S_SHR, 16'h1234);
    pceSlot("bb_load1", S_LOAD, 16'h8C3E);
    for (int i = 0; i < 3; i++) pceSlot("bb_shl", S_SHL, 16'h8C3E);
    checkOutput("bb_underrun", 16'(underrun), 16'h0);
    checkOutput("bb_busy", 16'(busy), 16'h1);

    // Word accepted in the same clk as the cnt==0 pce is not seen: underrun, then LOAD.
    applyStimulus(1'b1, 1'b1, 16'h0F0F, 1'b0);
    checkOutput("same_underrun", 16'(underrun), 16'h1);
    checkOutput("same_busy", 16'(busy), 16'h0);
    checkOutput("same_s", 16'(sh_s), 16'(S_HOLD));
    checkOutput("same_pending", 16'(bus.in_ready), 16'h0);
    tick();
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    pceSlot("same_load", S_LOAD, 16'h0F0F);
    pceSlot("mid_shr1", S_SHR, 16'h0F0F);
    pceSlot("mid_shr2", S_SHR, 16'h0F0F);

    // Reset mid-SHIFT with a word pending: everything drops.
    applyStimulus(1'b0, 1'b1, 16'h7777, 1'b0);
    checkOutput("mid_pending", 16'(bus.in_ready), 16'h0);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_cen", 16'(sh_cen), 16'h0);
    checkOutput("mid_rst_cr_n", 16'(sh_cr_n), 16'h0);
    checkOutput("mid_rst_ready", 16'(bus.in_ready), 16'h0);
    checkOutput("mid_rst_busy", 16'(busy), 16'h0);
    checkOutput("mid_rst_d", sh_d, 16'h0);
    rst = 1'b0;
    tick();
    checkOutput("mid_rel_ready", 16'(bus.in_ready), 16'h1);
    checkOutput("mid_rel_cr_n", 16'(sh_cr_n), 16'h1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("mid_no_cen", 16'(sh_cen), 16'h0);
    checkOutput("mid_no_busy", 16'(busy), 16'h0);
    checkOutput("mid_no_underrun", 16'(underrun), 16'h0);

    // PIXELS=1 instance: every pce with a pending word is a LOAD.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 16'h4321;
    tick();
    bus1.in_valid = 1'b0;
    checkOutput("p1_pend", 16'(bus1.in_ready), 16'h0);
    pce1 = 1'b1;
    tick();
    pce1 = 1'b0;
    checkOutput("p1_load0_cen", 16'(p1_cen), 16'h1);
    checkOutput("p1_load0_s", 16'(p1_s), 16'(S_LOAD));
    checkOutput("p1_load0_d", p1_d, 16'h4321);
    checkOutput("p1_load0_ready", 16'(bus1.in_ready), 16'h1);
    checkOutput("p1_load0_busy", 16'(p1_busy), 16'h0);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 16'h9999;
    tick();
    bus1.in_valid = 1'b0;
    checkOutput("p1_cen_low", 16'(p1_cen), 16'h0);
    pce1 = 1'b1;
    tick();
    pce1 = 1'b0;
    checkOutput("p1_load1_cen", 16'(p1_cen), 16'h1);
    checkOutput("p1_load1_d", p1_d, 16'h9999);
    checkOutput("p1_load1_ready", 16'(bus1.in_ready), 16'h1);
    tick();
    pce1 = 1'b1;
    tick();
    pce1 = 1'b0;
    checkOutput("p1_idle_cen", 16'(p1_cen), 16'h0);
    checkOutput("p1_idle_underrun", 16'(p1_underrun), 16'h0);
    checkOutput("p1_idle_s", 16'(p1_s), 16'(S_LOAD));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
